mem_arbiter: RTL and testbench

- Shares the single main-memory port between the I-cache and D-cache miss/write-back interfaces.
- Each cache sees a private memory port with the same handshake as the real memory.
- The arbiter grants one request at a time, latches its address and write data, and drives the memory port.
- It routes the memory response back to the granted cache as a one-cycle ready pulse with registered read data.

---
 rtl/mem_arbiter_pkg.sv | 18 +
 rtl/mem_arbiter.sv | 126 ++++++++++++
 tb/tb_mem_arbiter.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the I-cache/D-cache main-memory arbiter.
// Holds the FSM state encoding, the grant encoding and the default bus widths.
package mem_arbiter_pkg;

  localparam int DEF_ADDR_W = 28;
  localparam int DEF_DATA_W = 128;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BUSY    = 2'd1,
    ST_RESP    = 2'd2,
    ST_RELEASE = 2'd3
  } state_t;

  localparam logic GNT_I = 1'b0;
  localparam logic GNT_D = 1'b1;

endpackage

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one main-memory port between the I-cache and D-cache.
// One transaction at a time: IDLE -> BUSY -> RESP (ready pulse) -> RELEASE -> IDLE.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [DATA_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [DATA_W-1:0] d_mem_wdata,
  output logic [DATA_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output state_t            dbg_state,
  output logic              dbg_grant
);

  // Handshake: each cache holds its request until its one-cycle ready pulse;
  // the memory strobe is held until mem_ready, which is honoured only in BUSY.

  state_t state;
  logic   grant;
  logic   last_grant;
  logic   i_req;
  logic   d_req;
  logic   pick;

  function automatic logic rr_pick(input logic i_r, input logic d_r, input logic last);
    if (i_r && d_r) begin
      return ~last;
    end else if (d_r) begin
      return GNT_D;
    end else begin
      return GNT_I;
    end
  endfunction

  assign i_req     = i_mem_read;
  assign d_req     = d_mem_read | d_mem_write;
  assign pick      = rr_pick(i_req, d_req, last_grant);
  assign dbg_state = state;
  assign dbg_grant = grant;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= ST_IDLE;
      grant       <= GNT_I;
      last_grant  <= GNT_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_mem_rdata <= '0;
      d_mem_rdata <= '0;
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
    end else begin
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_req || d_req) begin
            grant      <= pick;
            last_grant <= pick;
            state      <= ST_BUSY;
            if (pick == GNT_D) begin
              // Read+write together is illegal; the write wins.
              mem_addr  <= d_mem_addr;
              mem_wdata <= d_mem_wdata;
              mem_write <= d_mem_write;
              mem_read  <= d_mem_read & ~d_mem_write;
            end else begin
              mem_addr  <= i_mem_addr;
              mem_wdata <= '0;
              mem_write <= 1'b0;
              mem_read  <= 1'b1;
            end
          end
        end
        ST_BUSY: begin
          if (mem_ready) begin
            // Only read completions update the cache's rdata register.
            if (mem_read) begin
              if (grant == GNT_D) begin
                d_mem_rdata <= mem_rdata;
              end else begin
                i_mem_rdata <= mem_rdata;
              end
            end
            if (grant == GNT_D) begin
              d_mem_ready <= 1'b1;
            end else begin
              i_mem_ready <= 1'b1;
            end
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: reset, single-cache reads/writes, round-robin
// alternation, ignored input changes, stray mem_ready, illegal D op, async reset.
module tb_mem_arbiter;
  import mem_arbiter_pkg::*;

  logic         clk;
  logic         rst;
  logic         i_mem_read;
  logic [27:0]  i_mem_addr;
  logic [127:0] i_mem_rdata;
  logic         i_mem_ready;
  logic         d_mem_read;
  logic         d_mem_write;
  logic [27:0]  d_mem_addr;
  logic [127:0] d_mem_wdata;
  logic [127:0] d_mem_rdata;
  logic         d_mem_ready;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
  state_t       dbg_state;
  logic         dbg_grant;

  int total = 0;
  int bad   = 0;
  logic [127:0] exp_i_rdata;
  logic [127:0] exp_d_rdata;

  mem_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .i_mem_read  (i_mem_read),
    .i_mem_addr  (i_mem_addr),
    .i_mem_rdata (i_mem_rdata),
    .i_mem_ready (i_mem_ready),
    .d_mem_read  (d_mem_read),
    .d_mem_write (d_mem_write),
    .d_mem_addr  (d_mem_addr),
    .d_mem_wdata (d_mem_wdata),
    .d_mem_rdata (d_mem_rdata),
    .d_mem_ready (d_mem_ready),
    .mem_read    (mem_read),
    .mem_write   (mem_write),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata),
    .mem_ready   (mem_ready),
    .dbg_state   (dbg_state),
    .dbg_grant   (dbg_grant)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_rdata();
    chk("i_rdata", i_mem_rdata, exp_i_rdata);
    chk("d_rdata", d_mem_rdata, exp_d_rdata);
  endtask

  // Requests must already be driven and the arbiter in IDLE.
  task automatic run_txn(input logic g, input logic [27:0] a, input logic wr,
                         input logic [127:0] wd, input logic [127:0] rd, input int nbusy);
    tick();
    for (int c = 0; c < nbusy; c++) begin
      chk("busy_state", dbg_state, ST_BUSY);
      chk("busy_grant", dbg_grant, g);
      chk("busy_addr", mem_addr, a);
      chk("busy_read", mem_read, !wr);
      chk("busy_write", mem_write, wr);
      if (wr) chk("busy_wdata", mem_wdata, wd);
      chk("busy_i_ready", i_mem_ready, 1'b0);
      chk("busy_d_ready", d_mem_ready, 1'b0);
      if (c < nbusy - 1) tick();
    end
    mem_ready = 1'b1;
    mem_rdata = rd;
    tick();
    mem_ready = 1'b0;
    mem_rdata = '0;
    if (!wr) begin
      if (g == GNT_D) exp_d_rdata = rd;
      else exp_i_rdata = rd;
    end
    chk("resp_state", dbg_state, ST_RESP);
    chk("resp_i_ready", i_mem_ready, g == GNT_I);
    chk("resp_d_ready", d_mem_ready, g == GNT_D);
    chk("resp_read_low", mem_read, 1'b0);
    chk("resp_write_low", mem_write, 1'b0);
    chk_rdata();
    tick();
    chk("rel_state", dbg_state, ST_RELEASE);
    chk("rel_i_ready", i_mem_ready, 1'b0);
    chk("rel_d_ready", d_mem_ready, 1'b0);
    tick();
    chk("idle_state", dbg_state, ST_IDLE);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_i_rdata = '0;
    exp_d_rdata = '0;
    tick();
    tick();
    chk("rst_state", dbg_state, ST_IDLE);
    chk("rst_mem_read", mem_read, 1'b0);
    chk("rst_mem_write", mem_write, 1'b0);
    chk("rst_mem_addr", mem_addr, '0);
    chk("rst_mem_wdata", mem_wdata, '0);
    chk("rst_i_ready", i_mem_ready, 1'b0);
    chk("rst_d_ready", d_mem_ready, 1'b0);
    chk_rdata();
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    i_mem_read = 1'b0; i_mem_addr = '0;
    d_mem_read = 1'b0; d_mem_write = 1'b0; d_mem_addr = '0; d_mem_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    exp_i_rdata = '0; exp_d_rdata = '0;
    do_reset();
    tick();
    chk("idle_after_reset", dbg_state, ST_IDLE);

    // I-only read: BUSY cycles 1..4, mem_ready in cycle 4, i ready in cycle 5.
    i_mem_read = 1'b1; i_mem_addr = 28'h0000010;
    run_txn(GNT_I, 28'h0000010, 1'b0, '0, 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF, 4);
    i_mem_read = 1'b0;

    // D write-back held over 3 BUSY cycles.
    d_mem_write = 1'b1; d_mem_addr = 28'h0000020;
    d_mem_wdata = 128'h12345678_9ABCDEF0_0FEDCBA9_87654321;
    run_txn(GNT_D, 28'h0000020, 1'b1, 128'h12345678_9ABCDEF0_0FEDCBA9_87654321,
            128'hBAD0BAD0_BAD0BAD0_BAD0BAD0_BAD0BAD0, 3);
    d_mem_write = 1'b0;

    // Stray mem_ready while IDLE does nothing.
    mem_ready = 1'b1; mem_rdata = 128'hFFFF0000_FFFF0000_FFFF0000_FFFF0000;
    tick();
    mem_ready = 1'b0; mem_rdata = '0;
    chk("stray_state", dbg_state, ST_IDLE);
    chk("stray_i_ready", i_mem_ready, 1'b0);
    chk("stray_d_ready", d_mem_ready, 1'b0);
    chk("stray_read", mem_read, 1'b0);
    chk_rdata();

    // Address change during BUSY is ignored.
    i_mem_read = 1'b1; i_mem_addr = 28'h0000030;
    tick();
    chk("chg_addr0", mem_addr, 28'h0000030);
    i_mem_addr = 28'h0000099;
    d_mem_write = 1'b1;
    tick();
    chk("chg_addr1", mem_addr, 28'h0000030);
    chk("chg_read", mem_read, 1'b1);
    chk("chg_write", mem_write, 1'b0);
    chk("chg_grant", dbg_grant, GNT_I);
    mem_ready = 1'b1; mem_rdata = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    tick();
    mem_ready = 1'b0;
    exp_i_rdata = 128'h0000_1111_2222_3333_4444_5555_6666_7777;
    chk("chg_i_ready", i_mem_ready, 1'b1);
    chk("chg_d_ready", d_mem_ready, 1'b0);
    chk_rdata();
    i_mem_read = 1'b0; d_mem_write = 1'b0;
    tick();
    tick();
    chk("chg_idle", dbg_state, ST_IDLE);

    // Illegal D read+write is a write; mem_ready in the first BUSY cycle.
    d_mem_read = 1'b1; d_mem_write = 1'b1; d_mem_addr = 28'h0000040;
    d_mem_wdata = 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A;
    run_txn(GNT_D, 28'h0000040, 1'b1, 128'hA5A5A5A5_5A5A5A5A_A5A5A5A5_5A5A5A5A,
            128'hCAFECAFE_CAFECAFE_CAFECAFE_CAFECAFE, 1);
    d_mem_read = 1'b0; d_mem_write = 1'b0;

    // Reset mid-BUSY clears everything immediately.
    i_mem_read = 1'b1; i_mem_addr = 28'h0000050;
    tick();
    chk("mid_read_before", mem_read, 1'b1);
    #2;
    rst = 1'b1;
    exp_i_rdata = '0; exp_d_rdata = '0;
    #1;
    chk("mid_read_async", mem_read, 1'b0);
    chk("mid_state_async", dbg_state, ST_IDLE);
    chk("mid_addr_async", mem_addr, '0);
    i_mem_read = 1'b0;
    tick();
    rst = 1'b0;
    chk("mid_i_ready", i_mem_ready, 1'b0);
    chk("mid_d_ready", d_mem_ready, 1'b0);
    tick();
    chk("mid_i_ready2", i_mem_ready, 1'b0);
    chk("mid_d_ready2", d_mem_ready, 1'b0);
    chk_rdata();
    d_mem_read = 1'b1; d_mem_addr = 28'h0000060;
    run_txn(GNT_D, 28'h0000060, 1'b0, '0, 128'h600D600D_600D600D_600D600D_600D600D, 2);
    d_mem_read = 1'b0;

    // Both caches requesting continuously after reset: D, I, D, I, ...
    do_reset();
    i_mem_read = 1'b1; i_mem_addr = 28'h0000100;
    d_mem_read = 1'b1; d_mem_addr = 28'h0000200;
    for (int k = 0; k < 8; k++) begin
      logic g;
      logic [127:0] rd;
      g  = (k % 2 == 0) ? GNT_D : GNT_I;
      rd = {96'h0, 32'hC0DE0000 + 32'(k)};
      run_txn(g, (g == GNT_D) ? 28'h0000200 : 28'h0000100, 1'b0, '0, rd, 2);
    end
    i_mem_read = 1'b0; d_mem_read = 1'b0;
    tick();
    chk("end_idle", dbg_state, ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
